// File: rtl/horner_mac_engine.sv
// Horner-rule polynomial evaluator over banked fixed-point coefficient tables.
// A sample x is accepted in IDLE. ITER then performs one multiply-accumulate
// step per cycle. DONE holds the result until the consumer takes it.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid source holds its data stable until that edge.
// in_ready_o depends only on state. out_valid_o never depends on out_ready_i.
module horner_mac_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int ADDR_LINES = 5,
  parameter int NUM_MODES  = 4,
  localparam int MAX_TERMS = 2 ** ADDR_LINES,
  localparam int MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  coeff_wr_en_i,
  input  logic [MODE_W-1:0]     coeff_wr_bank_i,
  input  logic [ADDR_LINES-1:0] coeff_wr_addr_i,
  input  logic [DATA_WIDTH-1:0] coeff_wr_data_i,
  output logic                  coeff_wr_err_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [MODE_W-1:0]     mode_i,
  input  logic [ADDR_LINES:0]   term_count_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_sat_o,
  output logic                  busy_o,
  output logic [1:0]            dbg_state_o
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int SW    = PW + 1;
  localparam int CNT_W = ADDR_LINES + 1;
  localparam int IDX_W = MODE_W + ADDR_LINES;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Coefficient storage is deliberately left without a reset.
  logic [DATA_WIDTH-1:0] coeff_q [NUM_MODES*MAX_TERMS];

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [MODE_W-1:0]     mode_q, mode_d;
  logic [ADDR_LINES-1:0] k_q, k_d;
  logic                  sat_q, sat_d;
  logic                  wr_err_q, wr_err_d;
  logic                  in_ready_q, out_valid_q, busy_q;

  logic                  accept;
  logic [CNT_W-1:0]      n_eff;
  logic [MODE_W-1:0]     rd_bank;
  logic [ADDR_LINES-1:0] rd_addr;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] coef_rd;
  logic                  wr_ok;
  logic signed [PW-1:0]  prod, prod_sh;
  logic signed [SW-1:0]  sum;
  logic [DATA_WIDTH-1:0] step_val;
  logic                  step_sat;

  // Accept decode, term clamp and the single coefficient read port.
  // In the accept cycle the port reads the top term. Otherwise it reads term k.
  always_comb begin
    accept  = in_valid_i && (state_q == S_IDLE);
    n_eff   = (term_count_i > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : term_count_i;
    rd_bank = accept ? mode_i : mode_q;
    rd_addr = accept ? (n_eff[ADDR_LINES-1:0] - ADDR_LINES'(1)) : k_q;
    rd_idx  = {((32'(rd_bank) < 32'(NUM_MODES)) ? rd_bank : '0), rd_addr};
    coef_rd = coeff_q[rd_idx];
  end

  // One Horner step: full product, floor shift, widened add, then saturate.
  always_comb begin
    prod     = PW'($signed(acc_q)) * PW'($signed(x_q));
    prod_sh  = prod >>> FRAC_BITS;
    sum      = SW'(prod_sh) + SW'($signed(coef_rd));
    step_sat = 1'b0;
    step_val = sum[DATA_WIDTH-1:0];
    if (sum > SAT_MAX) begin
      step_sat = 1'b1;
      step_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (sum < SAT_MIN) begin
      step_sat = 1'b1;
      step_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  // Write gating: reject banks that do not exist, and reject the bank in use while busy.
  always_comb begin
    wr_ok    = (32'(coeff_wr_bank_i) < 32'(NUM_MODES)) &&
               !((state_q != S_IDLE) && (coeff_wr_bank_i == mode_q));
    wr_err_d = coeff_wr_en_i && !wr_ok;
  end

  // Next-state and datapath update for IDLE, ITER and DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x_d     = x_q;
    mode_d  = mode_q;
    k_d     = k_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d    = in_data_i;
          mode_d = mode_i;
          sat_d  = 1'b0;
          k_d    = n_eff[ADDR_LINES-1:0] - ADDR_LINES'(2);
          if (n_eff == '0) begin
            acc_d   = '0;
            state_d = S_DONE;
          end else begin
            acc_d   = coef_rd;
            state_d = (n_eff == CNT_W'(1)) ? S_DONE : S_ITER;
          end
        end
      end
      S_ITER: begin
        acc_d = step_val;
        sat_d = sat_q | step_sat;
        k_d   = k_q - ADDR_LINES'(1);
        if (k_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Coefficient bank write port. Writes land at the edge, with no read forwarding.
  always_ff @(posedge clk_i) begin
    if (coeff_wr_en_i && wr_ok) coeff_q[{coeff_wr_bank_i, coeff_wr_addr_i}] <= coeff_wr_data_i;
  end

  // FSM state, datapath registers and the registered handshake and status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      x_q         <= '0;
      mode_q      <= '0;
      k_q         <= '0;
      sat_q       <= 1'b0;
      wr_err_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      mode_q      <= mode_d;
      k_q         <= k_d;
      sat_q       <= sat_d;
      wr_err_q    <= wr_err_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = out_valid_q;
  assign busy_o         = busy_q;
  assign out_data_o     = acc_q;
  assign out_sat_o      = sat_q;
  assign coeff_wr_err_o = wr_err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: doc/horner_mac_engine.md
HORNER_MAC_ENGINE -- requirements
Module: horner_mac_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: signed fixed-point operand/result width.
REQ-002 SHALL have parameter FRAC_BITS, default 16: fractional bits of all operands (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
REQ-003 SHALL have parameter ADDR_LINES, default 5: coefficient address width; MAX_TERMS = 2**ADDR_LINES.
REQ-004 SHALL have parameter NUM_MODES, default 4: coefficient banks (e.g. sigmoid, tanh, GeLU, spare); MODE_W = max(1, clog2(NUM_MODES)).
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 coeff_wr_en_i  in  1  coefficient write strobe.
REQ-008 coeff_wr_bank_i  in  MODE_W  target bank.
REQ-009 coeff_wr_addr_i  in  ADDR_LINES  term index k (coefficient of x^k).
REQ-010 coeff_wr_data_i  in  DATA_WIDTH  coefficient value.
REQ-011 coeff_wr_err_o  out  1  one-cycle pulse: write rejected.
REQ-012 in_valid_i / in_ready_o  in / out  1 each  sample handshake.
REQ-013 in_data_i  in  DATA_WIDTH  sample x.
REQ-014 mode_i  in  MODE_W  bank select, sampled on accept.
REQ-015 term_count_i  in  ADDR_LINES+1  number of terms N, sampled on accept.
REQ-016 out_valid_o / out_ready_i  out / in  1 each  result handshake.
REQ-017 out_data_o  out  DATA_WIDTH  polynomial result.
REQ-018 out_sat_o  out  1  sticky: saturation occurred during this evaluation.
REQ-019 busy_o  out  1  high in ITER and DONE.

Function
REQ-020 SHALL compute y = sum c[mode][k]*x^k for k = 0..N-1 by Horner: acc = c[N-1]; acc = acc*x + c[k] for k = N-2 down to 0.
REQ-021 SHALL use states IDLE, ITER, DONE; in_ready_o = (state==IDLE); out_valid_o = (state==DONE).
REQ-022 Accept = in_valid_i & in_ready_o; at the accept edge latch x, mode, N' = min(N, MAX_TERMS); acc <= c[N'-1], k <= N'-2.
REQ-023 N'=0: acc <= 0, go DONE. N'=1: acc <= c[0], go DONE. N'>=2: go ITER.
REQ-024 ITER: one Horner step per cycle; go DONE on the edge that processes k=0; out_valid_o high in the cycle after edge max(N'-1,0), accept edge counted as edge 0.
REQ-025 Step arithmetic: full 2*DATA_WIDTH signed product, arithmetic shift right FRAC_BITS (truncate toward -inf), add sign-extended c[k] at 2*DATA_WIDTH+1 bits, saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-026 Any saturating step SHALL set out_sat_o; cleared on next accept.
REQ-027 DONE: out_data_o, out_sat_o held stable while out_ready_i low; on out_valid_o & out_ready_i go IDLE next edge; no new accept in that cycle.
REQ-028 Coefficient write lands at the clock edge; a read in the same cycle returns the old value (no forwarding).
REQ-029 Write while busy_o to the bank latched for the current evaluation SHALL be dropped and pulse coeff_wr_err_o next cycle; writes to other banks always succeed.
REQ-030 coeff_wr_bank_i >= NUM_MODES SHALL be dropped with coeff_wr_err_o pulse.
REQ-031 Inputs in_data_i, mode_i, term_count_i SHALL be ignored outside the accept cycle.

Reset
REQ-032 rst_i high at an edge: state IDLE, in_ready_o=1 from next cycle, out_valid_o=0, out_data_o=0, out_sat_o=0, busy_o=0, coeff_wr_err_o=0, acc and k cleared.
REQ-033 Reset mid-ITER or mid-DONE SHALL abort the evaluation with no output handshake.
REQ-034 Coefficient banks SHALL NOT be reset; contents retained across rst_i, undefined after power-up.

Verification (DATA_WIDTH=16, FRAC_BITS=8)
REQ-035 Bank0 c={0x0100,0x0100,0x0080}, x=0x0100, N=3 -> out_data_o=0x0280, out_sat_o=0, out_valid_o after edge 2.
REQ-036 Bank1 c={0x0100,0x0100,0x0100}, x=0xFE00 (-2.0), N=3, mode=1 -> 0x0300; same x with mode=0 -> 0x0100.
REQ-037 Bank2 c={0x0000,0x7F00}, x=0x0200, N=2 -> 0x7FFF, out_sat_o=1; next evaluation without overflow -> out_sat_o=0.
REQ-038 N=0 -> 0x0000 one cycle after accept; N=1 -> c[0]; term_count_i=40 -> computed as N=32.
REQ-039 out_ready_i low 5 cycles in DONE -> out_data_o stable, in_ready_o=0, pending in_valid_i not accepted; write to active bank during ITER -> coeff_wr_err_o pulse, result unchanged.
REQ-040 rst_i pulse at ITER cycle 2 of an N=8 run -> out_valid_o never asserts, in_ready_o=1 after reset, next evaluation correct with retained coefficients.
